// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
//   Round-robin intersection controller for N_DIR approaches. Each service is
//   GREEN -> YELLOW -> ALLRED, with a down-counter timing every phase. With
//   SKIP_EN=1 only approaches holding a latched demand are served; idle time is
//   spent in all-red. A flashing-yellow maintenance mode overrides everything.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   demand       in   per-approach request (level or pulse), latched into pending
//   flash_en     in   maintenance flashing-yellow request
//   light        out  per approach i: bit 3i+2 = R, 3i+1 = Y, 3i = G (registered)
//   active_dir   out  approach owning green/yellow, or the one served last
//   green_start  out  one-cycle pulse aligned with the first green lamp cycle
//   pending      out  latched demand flags
//   dbg_state    out  current FSM state (GREEN=0, YELLOW=1, ALLRED=2, FLASH=3)

module traffic_intersection_ctrl #(
    parameter int N_DIR      = 3,
    parameter int CNT_W      = 8,
    parameter int T_GREEN    = 10,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 1,
    parameter int FLASH_HALF = 4,
    parameter int SKIP_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_DIR-1:0]     demand,
    input  logic                 flash_en,
    output logic [3*N_DIR-1:0]   light,
    output logic [2:0]           active_dir,
    output logic                 green_start,
    output logic [N_DIR-1:0]     pending,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   TMR_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0]   TMR_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0]   TMR_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0]   TMR_FLASH  = CNT_W'(FLASH_HALF - 1);
    localparam logic [2:0]         LAST_DIR   = 3'(N_DIR - 1);
    localparam logic [3*N_DIR-1:0] ALL_RED    = {N_DIR{3'b100}};

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     tmr_q, tmr_d;
    logic [2:0]           dir_q, dir_d;
    logic [N_DIR-1:0]     pending_q, pending_d;
    logic                 gs_q, gs_d;
    logic                 fphase_q, fphase_d;
    logic [CNT_W-1:0]     fcnt_q, fcnt_d;
    logic [3*N_DIR-1:0]   light_q, light_d;

    logic [2:0]           fixed_next;
    logic                 scan_found;
    logic [2:0]           scan_dir;
    int                   scan_dist;
    int                   scan_best;
    logic                 enter_green;

    // Next approach. The scan ranks every pending approach by its distance
    // after dir_q (wrapping modulo N_DIR), so dir_q itself ranks last.
    always_comb begin
        fixed_next = (dir_q == LAST_DIR) ? 3'd0 : dir_q + 3'd1;
        scan_found = 1'b0;
        scan_dir   = dir_q;
        scan_best  = N_DIR;
        scan_dist  = 0;
        for (int i = 0; i < N_DIR; i++) begin
            scan_dist = i - int'(dir_q) - 1;
            if (scan_dist < 0) scan_dist = scan_dist + N_DIR;
            if (pending_q[i] && (scan_dist < scan_best)) begin
                scan_best  = scan_dist;
                scan_found = 1'b1;
                scan_dir   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        dir_d    = dir_q;
        fphase_d = fphase_q;
        fcnt_d   = fcnt_q;
        if (flash_en && (state_q != ST_FLASH)) begin
            // Any timed phase is abandoned; flashing starts with yellow lit.
            state_d  = ST_FLASH;
            fphase_d = 1'b1;
            fcnt_d   = TMR_FLASH;
        end else begin
            case (state_q)
                ST_GREEN: begin
                    if (tmr_q == '0) begin
                        state_d = ST_YELLOW;
                        tmr_d   = TMR_YELLOW;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_YELLOW: begin
                    if (tmr_q == '0) begin
                        state_d = ST_ALLRED;
                        tmr_d   = TMR_ALLRED;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_ALLRED: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - 1'b1;
                    end else if (SKIP_EN == 0) begin
                        state_d = ST_GREEN;
                        tmr_d   = TMR_GREEN;
                        dir_d   = fixed_next;
                    end else if (scan_found) begin
                        state_d = ST_GREEN;
                        tmr_d   = TMR_GREEN;
                        dir_d   = scan_dir;
                    end
                    // Otherwise idle in all-red with tmr held at zero.
                end
                ST_FLASH: begin
                    if (!flash_en) begin
                        // Rotation resumes after the approach served last.
                        state_d = ST_ALLRED;
                        tmr_d   = TMR_ALLRED;
                    end else if (fcnt_q == '0) begin
                        fphase_d = ~fphase_q;
                        fcnt_d   = TMR_FLASH;
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ALLRED;
                    tmr_d   = TMR_ALLRED;
                end
            endcase
        end
    end

    assign enter_green = (state_d == ST_GREEN) && (state_q != ST_GREEN);
    assign gs_d        = enter_green;

    // Demand for the approach currently in green is ignored; the clear on
    // green entry beats a coincident demand.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < N_DIR; i++) begin
            pending_d[i] = (pending_q[i] |
                            (demand[i] && !((state_q == ST_GREEN) && (dir_q == 3'(i)))))
                           & ~(enter_green && (dir_d == 3'(i)));
        end
    end

    // Lamps are decoded from the next state so they change on the same edge.
    always_comb begin
        light_d = ALL_RED;
        for (int i = 0; i < N_DIR; i++) begin
            if (state_d == ST_FLASH) begin
                light_d[3*i +: 3] = {1'b0, fphase_d, 1'b0};
            end else if ((state_d == ST_GREEN) && (dir_d == 3'(i))) begin
                light_d[3*i +: 3] = 3'b001;
            end else if ((state_d == ST_YELLOW) && (dir_d == 3'(i))) begin
                light_d[3*i +: 3] = 3'b010;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ALLRED;
            tmr_q     <= TMR_ALLRED;
            dir_q     <= LAST_DIR;
            pending_q <= '0;
            gs_q      <= 1'b0;
            fphase_q  <= 1'b0;
            fcnt_q    <= '0;
            light_q   <= ALL_RED;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            gs_q      <= gs_d;
            fphase_q  <= fphase_d;
            fcnt_q    <= fcnt_d;
            light_q   <= light_d;
        end
    end

    assign light       = light_q;
    assign active_dir  = dir_q;
    assign green_start = gs_q;
    assign pending     = pending_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl
//   Directed bench for traffic_intersection_ctrl with N_DIR=3, T_GREEN=4,
//   T_YELLOW=2, T_ALLRED=1, FLASH_HALF=3. dut0 runs fixed rotation, dut1 runs
//   demand skipping. Expected per-cycle outputs are queued as stimulus is
//   planned and popped one per clock.

module tb_traffic_intersection_ctrl;

    localparam int N_DIR = 3;
    localparam logic [8:0] ALL_RED = 9'b100_100_100;
    localparam logic [8:0] FL_ON   = 9'b010_010_010;
    localparam logic [8:0] FL_OFF  = 9'b000_000_000;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, flash0, gs0;
    logic [2:0] demand0, ad0, pend0;
    logic [8:0] light0;
    logic [1:0] st0;

    logic       rst1, flash1, gs1;
    logic [2:0] demand1, ad1, pend1;
    logic [8:0] light1;
    logic [1:0] st1;

    traffic_intersection_ctrl #(
        .N_DIR(3), .CNT_W(8), .T_GREEN(4), .T_YELLOW(2), .T_ALLRED(1),
        .FLASH_HALF(3), .SKIP_EN(0)
    ) dut0 (
        .clk(clk), .rst(rst0), .demand(demand0), .flash_en(flash0),
        .light(light0), .active_dir(ad0), .green_start(gs0),
        .pending(pend0), .dbg_state(st0)
    );

    traffic_intersection_ctrl #(
        .N_DIR(3), .CNT_W(8), .T_GREEN(4), .T_YELLOW(2), .T_ALLRED(1),
        .FLASH_HALF(3), .SKIP_EN(1)
    ) dut1 (
        .clk(clk), .rst(rst1), .demand(demand1), .flash_en(flash1),
        .light(light1), .active_dir(ad1), .green_start(gs1),
        .pending(pend1), .dbg_state(st1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Entry layout: {light[8:0], green_start, active_dir[2:0], pending[2:0]}
    logic [15:0] exp_q[$];

    function automatic logic [8:0] lamp1(input int d, input logic [2:0] code);
        logic [8:0] v;
        v = ALL_RED;
        v[3*d +: 3] = code;
        return v;
    endfunction

    task automatic push(input logic [8:0] l, input logic gs, input int ad,
                        input logic [2:0] pd, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({l, (i == 0) ? gs : 1'b0, 3'(ad), pd});
    endtask

    // One full service of approach d: G x4, Y x2, AR x1.
    task automatic push_service(input int d, input logic [2:0] pd_g,
                                input logic [2:0] pd_y2, input logic [2:0] pd_ar);
        push(lamp1(d, 3'b001), 1'b1, d, pd_g, 4);
        push(lamp1(d, 3'b010), 1'b0, d, pd_g, 1);
        push(lamp1(d, 3'b010), 1'b0, d, pd_y2, 1);
        push(ALL_RED, 1'b0, d, pd_ar, 1);
    endtask

    task automatic sample_cmp(input int sel, input string tag);
        logic [15:0] got, exp;
        logic [8:0]  l;
        int          nonred;
        logic        ok;
        got = (sel == 0) ? {light0, gs0, ad0, pend0} : {light1, gs1, ad1, pend1};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: nothing expected, got %h", tag, got);
            return;
        end
        exp = exp_q.pop_front();
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got light=%b gs=%b dir=%0d pend=%b, expected light=%b gs=%b dir=%0d pend=%b",
                   tag, got[15:7], got[6], got[5:3], got[2:0],
                   exp[15:7], exp[6], exp[5:3], exp[2:0]);
        end
        if ((exp[15:7] != FL_ON) && (exp[15:7] != FL_OFF)) begin
            l = got[15:7];
            ok = 1'b1;
            nonred = 0;
            for (int d = 0; d < N_DIR; d++) begin
                if ($countones(l[3*d +: 3]) != 1) ok = 1'b0;
                if (!l[3*d+2]) nonred++;
            end
            if (nonred > 1) ok = 1'b0;
            n_cmp++;
            assert (ok) else begin
                n_bad++;
                $error("FAIL %s_lamp_rule: got light=%b, expected one lamp per approach and at most one non-red",
                       tag, l);
            end
        end
    endtask

    task automatic check_cycles(input int sel, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sample_cmp(sel, tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; flash0 = 1'b0; demand0 = 3'b000;
        rst1 = 1'b1; flash1 = 1'b0; demand1 = 3'b000;
        repeat (2) @(posedge clk);

        // Fixed rotation from reset: one all-red cycle then G0, Y0, AR, G1...
        @(negedge clk);
        rst0 = 1'b0;
        #1;
        push(ALL_RED, 1'b0, 2, 3'b000, 1);
        sample_cmp(0, "reset0");
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < N_DIR; d++)
                push_service(d, 3'b000, 3'b000, 3'b000);
        check_cycles(0, 42, "rotation");

        // Flash requested during the second cycle of G1.
        push_service(0, 3'b000, 3'b000, 3'b000);
        push(lamp1(1, 3'b001), 1'b1, 1, 3'b000, 2);
        check_cycles(0, 9, "pre_flash");
        flash0 = 1'b1;
        push(FL_ON, 1'b0, 1, 3'b000, 3);
        push(FL_OFF, 1'b0, 1, 3'b000, 3);
        push(FL_ON, 1'b0, 1, 3'b000, 3);
        push(FL_OFF, 1'b0, 1, 3'b000, 3);
        check_cycles(0, 12, "flash");
        flash0 = 1'b0;
        push(ALL_RED, 1'b0, 1, 3'b000, 1);
        push_service(2, 3'b000, 3'b000, 3'b000);
        push(lamp1(0, 3'b001), 1'b1, 0, 3'b000, 4);
        push(lamp1(0, 3'b010), 1'b0, 0, 3'b000, 1);
        check_cycles(0, 13, "post_flash");

        // Asynchronous reset between edges during Y0.
        #2;
        rst0 = 1'b1;
        #1;
        push(ALL_RED, 1'b0, 2, 3'b000, 1);
        sample_cmp(0, "async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        #1;
        push(ALL_RED, 1'b0, 2, 3'b000, 1);
        sample_cmp(0, "reset0_again");
        for (int d = 0; d < N_DIR; d++)
            push_service(d, 3'b000, 3'b000, 3'b000);
        check_cycles(0, 21, "restart");

        // Demand skipping: idle all-red, then a single pulse on approach 2.
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        push(ALL_RED, 1'b0, 2, 3'b000, 1);
        sample_cmp(1, "reset1");
        push(ALL_RED, 1'b0, 2, 3'b000, 5);
        check_cycles(1, 5, "idle");
        demand1 = 3'b100;
        push(ALL_RED, 1'b0, 2, 3'b100, 1);
        check_cycles(1, 1, "latch2");
        demand1 = 3'b000;
        push(lamp1(2, 3'b001), 1'b1, 2, 3'b000, 4);
        push(lamp1(2, 3'b010), 1'b0, 2, 3'b000, 2);
        push(ALL_RED, 1'b0, 2, 3'b000, 6);
        check_cycles(1, 12, "serve2");

        // Held demand on approaches 0 and 2: approach 1 is always skipped.
        demand1 = 3'b101;
        push(ALL_RED, 1'b0, 2, 3'b101, 1);
        check_cycles(1, 1, "latch101");
        for (int r = 0; r < 2; r++) begin
            push_service(0, 3'b100, 3'b101, 3'b101);
            push_service(2, 3'b001, 3'b101, 3'b101);
        end
        check_cycles(1, 28, "alternate");
        demand1 = 3'b000;

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_bad++;
            $error("FAIL drain: got %0d leftover expectations, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
